// File: rtl/hnoc_pkg.sv
// Shared fabric types for the leaf/tree switch arbiters.
// Port count, port index type and arbiter FSM states.
package hnoc_pkg;

  localparam int NUM_PORTS = 3;

  typedef logic [1:0] port_idx_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first valid requester after i_last (mod 3).
// Ports: i_valid (request vector), i_last (previous winner),
//        o_idx (next winner), o_any_valid (any request present).
module rr_picker
  import hnoc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_valid,
  input  port_idx_t            i_last,
  output port_idx_t            o_idx,
  output logic                 o_any_valid
);

  port_idx_t w_cand;

  // Scan from lowest to highest priority so the
  // highest-priority valid requester is written last.
  always_comb begin
    o_idx       = '0;
    o_any_valid = 1'b0;
    w_cand      = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_cand = port_idx_t'((32'(i_last) + k) % NUM_PORTS);
      if (i_valid[w_cand]) begin
        o_idx       = w_cand;
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_port_arbiter.sv
// Burst-limited round-robin arbiter for one switch output link.
// Ports: three valid/ready requesters (i_dataN, i_data_validN, o_data_readyN),
//        registered output (o_data, o_data_valid, i_data_ready),
//        status (o_grant one-hot, o_busy), i_clk, i_reset (async, active-high).
module switch_port_arbiter
  import hnoc_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DataWidth-1:0] i_data0,
  input  logic [DataWidth-1:0] i_data1,
  input  logic [DataWidth-1:0] i_data2,
  input  logic                 i_data_valid0,
  input  logic                 i_data_valid1,
  input  logic                 i_data_valid2,
  output logic                 o_data_ready0,
  output logic                 o_data_ready1,
  output logic                 o_data_ready2,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic [2:0]           o_grant,
  output logic                 o_busy
);

  localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MaxBurst - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  port_idx_t            r_grant;
  port_idx_t            w_grant_nxt;
  port_idx_t            r_last;
  port_idx_t            w_last_nxt;
  logic [CntW-1:0]      r_beat;
  logic [CntW-1:0]      w_beat_nxt;
  logic [DataWidth-1:0] r_data;
  logic                 r_data_valid;

  logic [NUM_PORTS-1:0] w_valid;
  port_idx_t            w_pick;
  logic                 w_any;
  logic                 w_out_free;
  logic                 w_gvalid;
  logic                 w_xfer;
  logic                 w_granted;
  logic [DataWidth-1:0] w_gdata;

  assign w_valid = {i_data_valid2, i_data_valid1, i_data_valid0};

  rr_picker u_picker (
    .i_valid     (w_valid),
    .i_last      (r_last),
    .o_idx       (w_pick),
    .o_any_valid (w_any)
  );

  // Output slot is free when empty or draining this cycle.
  assign w_out_free = !r_data_valid || i_data_ready;
  assign w_granted  = (r_state == GRANT);
  assign w_gvalid   = w_valid[r_grant];
  assign w_xfer     = w_granted && w_gvalid && w_out_free;

  always_comb begin
    w_gdata = i_data0;
    case (r_grant)
      2'd1:    w_gdata = i_data1;
      2'd2:    w_gdata = i_data2;
      default: w_gdata = i_data0;
    endcase
  end

  assign o_data_ready0 = w_granted && (r_grant == 2'd0) && w_out_free;
  assign o_data_ready1 = w_granted && (r_grant == 2'd1) && w_out_free;
  assign o_data_ready2 = w_granted && (r_grant == 2'd2) && w_out_free;

  assign o_grant      = w_granted ? (3'b001 << r_grant) : 3'b000;
  assign o_busy       = w_granted;
  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (!w_gvalid) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end else if (w_xfer) begin
          if (r_beat == LastBeat) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_grant;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= 2'd2;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // A new flit refills the slot even while the old one drains.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data       <= w_gdata;
      r_data_valid <= 1'b1;
    end else if (i_data_ready) begin
      r_data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Self-checking bench for switch_port_arbiter (MaxBurst=4 and MaxBurst=1).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_switch_port_arbiter;

  localparam int DW = 32;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] d  [NI][3];
  logic          v  [NI][3];
  logic          dr [NI];
  logic          r  [NI][3];
  logic [DW-1:0] od [NI];
  logic          ov [NI];
  logic [2:0]    og [NI];
  logic          ob [NI];

  switch_port_arbiter #(.DataWidth(DW), .MaxBurst(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst),
    .i_data0(d[0][0]), .i_data1(d[0][1]), .i_data2(d[0][2]),
    .i_data_valid0(v[0][0]), .i_data_valid1(v[0][1]),
    .i_data_valid2(v[0][2]),
    .o_data_ready0(r[0][0]), .o_data_ready1(r[0][1]),
    .o_data_ready2(r[0][2]),
    .o_data(od[0]), .o_data_valid(ov[0]), .i_data_ready(dr[0]),
    .o_grant(og[0]), .o_busy(ob[0])
  );

  switch_port_arbiter #(.DataWidth(DW), .MaxBurst(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_data0(d[1][0]), .i_data1(d[1][1]), .i_data2(d[1][2]),
    .i_data_valid0(v[1][0]), .i_data_valid1(v[1][1]),
    .i_data_valid2(v[1][2]),
    .o_data_ready0(r[1][0]), .o_data_ready1(r[1][1]),
    .o_data_ready2(r[1][2]),
    .o_data(od[1]), .o_data_valid(ov[1]), .i_data_ready(dr[1]),
    .o_grant(og[1]), .o_busy(ob[1])
  );

  int mb [NI] = '{4, 1};
  int total, bad, cyc;

  int            rem    [NI][3];
  int            seq    [NI][3];
  int            gap    [NI][3];
  logic [DW-1:0] base   [NI][3];
  int            stride [NI];
  int            dr_mode[NI];
  bit            gaps_on;

  bit            m_busy [NI];
  int            m_own  [NI];
  int            m_cnt  [NI];
  int            m_last [NI];
  bit            m_ov   [NI];
  logic [DW-1:0] m_od   [NI];

  logic [DW-1:0] outq [NI][$];
  int            outc [NI][$];
  logic [2:0]    gq   [NI][$];

  function automatic void m_reset(int i);
    m_busy[i] = 0;
    m_own[i]  = 0;
    m_cnt[i]  = 0;
    m_last[i] = 2;
    m_ov[i]   = 0;
    m_od[i]   = '0;
  endfunction

  function automatic void clear_stim();
    for (int i = 0; i < NI; i++) begin
      stride[i]  = 1;
      dr_mode[i] = 0;
      for (int n = 0; n < 3; n++) begin
        rem[i][n]  = 0;
        seq[i][n]  = 0;
        gap[i][n]  = 0;
        base[i][n] = '0;
      end
      outq[i].delete();
      outc[i].delete();
      gq[i].delete();
    end
    gaps_on = 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 3; n++) begin
        v[i][n] = (rem[i][n] > 0) && (gap[i][n] == 0);
        d[i][n] = base[i][n] + DW'(seq[i][n] * stride[i]);
      end
      case (dr_mode[i])
        1:       dr[i] = 1'b0;
        2:       dr[i] = 1'($urandom_range(0, 1));
        default: dr[i] = 1'b1;
      endcase
    end
  endtask

  // Called at drive phase; applies the arbitration rules and
  // advances to just after the next rising edge.
  task automatic finish_cycle();
    bit acc [NI][3];
    for (int i = 0; i < NI; i++) begin
      bit free;
      bit xfer;
      bit found;
      int p;
      if (ov[i] && dr[i]) begin
        outq[i].push_back(od[i]);
        outc[i].push_back(cyc);
      end
      for (int n = 0; n < 3; n++) acc[i][n] = 0;
      free = !m_ov[i] || dr[i];
      xfer = 0;
      if (!m_busy[i]) begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          p = (m_last[i] + k) % 3;
          if (!found && v[i][p]) begin
            found     = 1;
            m_busy[i] = 1;
            m_own[i]  = p;
            m_cnt[i]  = 0;
          end
        end
      end else if (!v[i][m_own[i]]) begin
        m_busy[i] = 0;
        m_last[i] = m_own[i];
      end else if (free) begin
        xfer = 1;
        acc[i][m_own[i]] = 1;
        m_od[i] = d[i][m_own[i]];
        if (m_cnt[i] == mb[i] - 1) begin
          m_busy[i] = 0;
          m_last[i] = m_own[i];
        end else begin
          m_cnt[i]++;
        end
      end
      if (xfer) m_ov[i] = 1;
      else if (dr[i]) m_ov[i] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 3; n++) begin
        if (acc[i][n]) begin
          seq[i][n]++;
          rem[i][n]--;
          gap[i][n] = gaps_on ? int'($urandom_range(0, 2)) : 0;
        end else if (gap[i][n] > 0) begin
          gap[i][n]--;
        end
      end
      if (og[i] != 3'b000 &&
          (gq[i].size() == 0 || gq[i][$] !== og[i]))
        gq[i].push_back(og[i]);
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    finish_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_stim();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) m_reset(i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_stim();
    drive();
    #2;
    total++;
    if (og[0] !== 3'b000 || ob[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_grant: got grant=%b busy=%b want 000/0", og[0], ob[0]);
    end
    total++;
    if (ov[0] !== 1'b0 || od[0] !== '0) begin
      bad++;
      $display("FAIL reset_out: got valid=%b data=%h want 0/0", ov[0], od[0]);
    end
    total++;
    if (r[0][0] !== 1'b0 || r[1][2] !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got %b%b want 00", r[0][0], r[1][2]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) m_reset(i);
    rem[0][1] = 100;
    base[0][1] = 32'h100;
    repeat (3) cycle();
    total++;
    if (og[0] !== 3'b010 || ov[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre: got grant=%b valid=%b want 010/1", og[0], ov[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (og[0] !== 3'b000 || ov[0] !== 1'b0 || ob[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got grant=%b valid=%b busy=%b want 000/0/0",
               og[0], ov[0], ob[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_reset(i);
      for (int n = 0; n < 3; n++) rem[i][n] = 100;
    end
    cycle();
    total++;
    if (og[0] !== 3'b001 || og[1] !== 3'b001) begin
      bad++;
      $display("FAIL reset_first_grant: got %b %b want 001 001", og[0], og[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_d [3];
    int guard;
    exp_d = '{32'hA0, 32'hB1, 32'hC2};
    do_reset();
    stride[1] = 0;
    for (int n = 0; n < 3; n++) begin
      base[1][n] = exp_d[n];
      rem[1][n]  = 100;
    end
    guard = 0;
    while (outq[1].size() < 7 && guard < 40) begin
      cycle();
      guard++;
    end
    total++;
    if (outq[1].size() < 7) begin
      bad++;
      $display("FAIL rr_timeout: got %0d flits want 7", outq[1].size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (outq[1][k] !== exp_d[k % 3]) begin
          bad++;
          $display("FAIL rr_order[%0d]: got %h want %h", k, outq[1][k], exp_d[k % 3]);
        end
        total++;
        if (outc[1][k+1] - outc[1][k] != 2) begin
          bad++;
          $display("FAIL rr_spacing[%0d]: got %0d want 2", k,
                   outc[1][k+1] - outc[1][k]);
        end
      end
    end
  endtask

  task automatic test_burst_limit();
    logic [2:0] exp_g [4];
    logic [DW-1:0] e;
    int guard;
    exp_g = '{3'b001, 3'b010, 3'b001, 3'b010};
    do_reset();
    base[0][0] = 32'h0000_0000;
    base[0][1] = 32'h0100_0000;
    rem[0][0]  = 100;
    rem[0][1]  = 100;
    guard = 0;
    while (outq[0].size() < 16 && guard < 60) begin
      cycle();
      guard++;
    end
    total++;
    if (outq[0].size() < 16) begin
      bad++;
      $display("FAIL burst_timeout: got %0d flits want 16", outq[0].size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        e = DW'(((k / 4) % 2) << 24) + DW'((k / 8) * 4 + (k % 4));
        total++;
        if (outq[0][k] !== e) begin
          bad++;
          $display("FAIL burst_flit[%0d]: got %h want %h", k, outq[0][k], e);
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      total++;
      if (gq[0].size() <= g || gq[0][g] !== exp_g[g]) begin
        bad++;
        $display("FAIL burst_grant[%0d]: got %b want %b", g,
                 (gq[0].size() > g) ? gq[0][g] : 3'bxxx, exp_g[g]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    int guard;
    do_reset();
    base[0][0] = 32'h100;
    rem[0][0]  = 8;
    guard = 0;
    while (ov[0] !== 1'b1 && guard < 10) begin
      cycle();
      guard++;
    end
    held = od[0];
    total++;
    if (held !== 32'h100) begin
      bad++;
      $display("FAIL bp_first: got %h want %h", held, 32'h100);
    end
    dr_mode[0] = 1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      total++;
      if (ov[0] !== 1'b1 || od[0] !== held || r[0][0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1/%h/0",
                 c, ov[0], od[0], r[0][0], held);
      end
    end
    dr_mode[0] = 0;
    guard = 0;
    while (outq[0].size() < 8 && guard < 40) begin
      cycle();
      guard++;
    end
    repeat (6) cycle();
    total++;
    if (outq[0].size() != 8) begin
      bad++;
      $display("FAIL bp_count: got %0d flits want 8", outq[0].size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (outq[0][k] !== 32'h100 + DW'(k)) begin
          bad++;
          $display("FAIL bp_flit[%0d]: got %h want %h", k, outq[0][k],
                   32'h100 + DW'(k));
        end
      end
    end
  endtask

  task automatic test_early_release();
    int guard;
    int n2;
    do_reset();
    base[0][0] = 32'h000;
    base[0][1] = 32'h100;
    base[0][2] = 32'h200;
    rem[0][2]  = 2;
    guard = 0;
    while (seq[0][2] < 2 && guard < 10) begin
      cycle();
      guard++;
    end
    rem[0][0] = 1;
    rem[0][1] = 1;
    cycle();
    total++;
    if (ob[0] !== 1'b0 || og[0] !== 3'b000) begin
      bad++;
      $display("FAIL early_idle: got busy=%b grant=%b want 0/000", ob[0], og[0]);
    end
    cycle();
    total++;
    if (og[0] !== 3'b001) begin
      bad++;
      $display("FAIL early_next: got %b want 001", og[0]);
    end
    guard = 0;
    while (outq[0].size() < 4 && guard < 20) begin
      cycle();
      guard++;
    end
    repeat (4) cycle();
    n2 = 0;
    foreach (outq[0][k]) if (outq[0][k][11:8] == 4'h2) n2++;
    total++;
    if (n2 != 2 || outq[0].size() != 4) begin
      bad++;
      $display("FAIL early_count: got %0d from req2, %0d total want 2, 4",
               n2, outq[0].size());
    end
  endtask

  task automatic test_drain_fill();
    do_reset();
    base[0][0] = 32'h1;
    rem[0][0]  = 4;
    cycle();
    for (int j = 1; j <= 4; j++) begin
      cycle();
      total++;
      if (ov[0] !== 1'b1 || od[0] !== DW'(j)) begin
        bad++;
        $display("FAIL drain_fill[%0d]: got valid=%b data=%h want 1/%h",
                 j, ov[0], od[0], DW'(j));
      end
    end
    cycle();
    total++;
    if (ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: got valid=%b want 0", ov[0]);
    end
  endtask

  task automatic test_random();
    int exp_s [NI][3];
    logic [2:0] eg;
    do_reset();
    gaps_on = 1;
    for (int i = 0; i < NI; i++) begin
      dr_mode[i] = 2;
      for (int n = 0; n < 3; n++) begin
        base[i][n]   = DW'(n << 24);
        rem[i][n]    = 100000;
        exp_s[i][n]  = 0;
      end
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        eg = m_busy[i] ? (3'b001 << m_own[i]) : 3'b000;
        total++;
        if (og[i] !== eg || ob[i] !== m_busy[i]) begin
          bad++;
          $display("FAIL rnd_grant[%0d] c%0d: got %b/%b want %b/%b",
                   i, c, og[i], ob[i], eg, m_busy[i]);
        end
        total++;
        if (ov[i] !== m_ov[i] || od[i] !== m_od[i]) begin
          bad++;
          $display("FAIL rnd_out[%0d] c%0d: got %b/%h want %b/%h",
                   i, c, ov[i], od[i], m_ov[i], m_od[i]);
        end
      end
      drive();
      #1;
      for (int i = 0; i < NI; i++) begin
        for (int n = 0; n < 3; n++) begin
          total++;
          if (r[i][n] !== (m_busy[i] && m_own[i] == n && (!m_ov[i] || dr[i]))) begin
            bad++;
            $display("FAIL rnd_ready[%0d][%0d] c%0d: got %b", i, n, c, r[i][n]);
          end
        end
      end
      finish_cycle();
    end
    for (int i = 0; i < NI; i++) begin
      foreach (outq[i][k]) begin
        int id;
        id = int'(outq[i][k][31:24]);
        total++;
        if (id > 2 || int'(outq[i][k][23:0]) != exp_s[i][id % 3]) begin
          bad++;
          $display("FAIL rnd_order[%0d] flit %0d: got %h", i, k, outq[i][k]);
        end
        if (id <= 2) exp_s[i][id] = int'(outq[i][k][23:0]) + 1;
      end
      total++;
      if (outq[i].size() < 100) begin
        bad++;
        $display("FAIL rnd_volume[%0d]: got %0d flits want >=100", i,
                 outq[i].size());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_early_release();
    test_drain_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
